// File: rtl/mau_dp_ram_pkg.sv
// rtl/mau_dp_ram_pkg.sv - shared types, mode encodings and helpers for mau_dp_ram
// Contents:
//   clr_state_e                clear sequencer states
//   READ_MODE_* / WRITE_MODE_* encodings of the READ_MODE / WRITE_MODE parameters
//   lane_count()               number of byte lanes in a word
package mau_dp_ram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    localparam int READ_MODE_1CYC           = 0;
    localparam int READ_MODE_2CYC           = 1;

    localparam int WRITE_MODE_READ_FIRST    = 0;
    localparam int WRITE_MODE_WRITE_THROUGH = 1;

    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mau_dp_ram_if.sv
// rtl/mau_dp_ram_if.sv - bus bundle between the MAU sequencers and mau_dp_ram
// Signals:
//   init_req / init_busy          clear request pulse / clear in progress
//   cea wrea bea ada dina         port A enable, write, byte lanes, address, write data
//   douta dvalida                 port A read data and one-cycle valid
//   ceb wreb beb adb dinb         port B request, as port A
//   doutb dvalidb                 port B read data and valid
//   collision                     both ports wrote overlapping lanes of one address
// Modports: master = sequencer side, slave = RAM side.
interface mau_dp_ram_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    import mau_dp_ram_pkg::*;

    localparam int LANES = lane_count(DATA_W);

    logic              init_req;
    logic              init_busy;

    logic              cea;
    logic              wrea;
    logic [LANES-1:0]  bea;
    logic [ADDR_W-1:0] ada;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;
    logic              dvalida;

    logic              ceb;
    logic              wreb;
    logic [LANES-1:0]  beb;
    logic [ADDR_W-1:0] adb;
    logic [DATA_W-1:0] dinb;
    logic [DATA_W-1:0] doutb;
    logic              dvalidb;

    logic              collision;

    modport master (
        output init_req,
        output cea, wrea, bea, ada, dina,
        output ceb, wreb, beb, adb, dinb,
        input  init_busy,
        input  douta, dvalida, doutb, dvalidb,
        input  collision
    );

    modport slave (
        input  init_req,
        input  cea, wrea, bea, ada, dina,
        input  ceb, wreb, beb, adb, dinb,
        output init_busy,
        output douta, dvalida, doutb, dvalidb,
        output collision
    );

endinterface

// File: rtl/mau_dp_ram_port.sv
// rtl/mau_dp_ram_port.sv - per-port read/write-through output path of mau_dp_ram
// Ports:
//   clk, resetn      shared clock, asynchronous active-low reset
//   busy_i           clear sequencer active; requests are dropped
//   ce_i, wr_i       access enable, write (1) / read (0)
//   be_i, din_i      byte-lane enables and write data
//   rd_word_i        current array word at this port's address (pre-write)
//   dout_o           held read / write-through data
//   dvalid_o         one-cycle valid for dout_o
module mau_dp_ram_port
    import mau_dp_ram_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int READ_MODE  = READ_MODE_1CYC,
    parameter int WRITE_MODE = WRITE_MODE_READ_FIRST,
    localparam int LANES     = lane_count(DATA_W)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              busy_i,
    input  logic              ce_i,
    input  logic              wr_i,
    input  logic [LANES-1:0]  be_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic [DATA_W-1:0] rd_word_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              dvalid_o
);

    localparam logic WT_EN = (WRITE_MODE == WRITE_MODE_WRITE_THROUGH);

    logic              accept;
    logic              rd_hit;
    logic              wt_hit;
    logic [DATA_W-1:0] merged;
    logic              s0_valid;
    logic [DATA_W-1:0] s0_data;
    logic              stg_valid;
    logic [DATA_W-1:0] stg_data;

    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dvalid_q, dvalid_d;

    // Word as it will read after this port's write: enabled lanes from din,
    // the rest from the pre-write array contents.
    always_comb begin
        merged = rd_word_i;
        for (int i = 0; i < LANES; i++) begin
            if (be_i[i]) begin
                merged[i*8 +: 8] = din_i[i*8 +: 8];
            end
        end
    end

    assign accept   = ce_i & ~busy_i;
    assign rd_hit   = accept & ~wr_i;
    assign wt_hit   = accept & wr_i & WT_EN;
    assign s0_valid = rd_hit | wt_hit;
    assign s0_data  = wr_i ? merged : rd_word_i;

    generate
        if (READ_MODE == READ_MODE_2CYC) begin : g_two_cycle
            logic              p_valid_q;
            logic [DATA_W-1:0] p_data_q;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    p_valid_q <= 1'b0;
                    p_data_q  <= '0;
                end else begin
                    p_valid_q <= s0_valid;
                    if (s0_valid) begin
                        p_data_q <= s0_data;
                    end
                end
            end

            assign stg_valid = p_valid_q;
            assign stg_data  = p_data_q;
        end else begin : g_one_cycle
            assign stg_valid = s0_valid;
            assign stg_data  = s0_data;
        end
    endgenerate

    // dout holds the last delivered word; only dvalid marks new data.
    always_comb begin
        dout_d   = stg_valid ? stg_data : dout_q;
        dvalid_d = stg_valid;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign dout_o   = dout_q;
    assign dvalid_o = dvalid_q;

endmodule

// File: rtl/mau_dp_ram.sv
// rtl/mau_dp_ram.sv - parametrised true dual-port RAM with byte lanes and clear sequencer
// Ports:
//   clk, resetn      single clock for both ports, asynchronous active-low reset
//   bus (slave)      init_req/init_busy, port A and B request/response, collision
module mau_dp_ram
    import mau_dp_ram_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 10,
    parameter int READ_MODE      = READ_MODE_1CYC,
    parameter int WRITE_MODE     = WRITE_MODE_READ_FIRST,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic         clk,
    input  logic         resetn,
    mau_dp_ram_if.slave  bus
);

    localparam int LANES = lane_count(DATA_W);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam clr_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_word_a;
    logic [DATA_W-1:0] rd_word_b;
    logic              wr_a;
    logic              wr_b;

    logic              collision_q, collision_d;

    // Clear sequencer: state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear sequencer: next state. cnt wraps back to 0 on the last address,
    // so a later request starts from address 0 again.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.init_req) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Clear sequencer: outputs
    always_comb begin
        busy = (state_q == ST_CLEAR);
    end

    assign bus.init_busy = busy;

    assign wr_a = bus.cea & bus.wrea & ~busy;
    assign wr_b = bus.ceb & bus.wreb & ~busy;

    // Port B's lane writes are issued after port A's, so on a same-address
    // overlap the later non-blocking update (B) lands on the shared lanes.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[cnt_q] <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_a && bus.bea[i]) begin
                    mem_q[bus.ada][i*8 +: 8] <= bus.dina[i*8 +: 8];
                end
            end
            for (int i = 0; i < LANES; i++) begin
                if (wr_b && bus.beb[i]) begin
                    mem_q[bus.adb][i*8 +: 8] <= bus.dinb[i*8 +: 8];
                end
            end
        end
    end

    // Pre-write contents: a read colliding with the other port's write
    // returns the old word.
    assign rd_word_a = mem_q[bus.ada];
    assign rd_word_b = mem_q[bus.adb];

    assign collision_d = wr_a & wr_b & (bus.ada == bus.adb) & (|(bus.bea & bus.beb));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    assign bus.collision = collision_q;

    mau_dp_ram_port #(
        .DATA_W     (DATA_W),
        .READ_MODE  (READ_MODE),
        .WRITE_MODE (WRITE_MODE)
    ) u_port_a (
        .clk       (clk),
        .resetn    (resetn),
        .busy_i    (busy),
        .ce_i      (bus.cea),
        .wr_i      (bus.wrea),
        .be_i      (bus.bea),
        .din_i     (bus.dina),
        .rd_word_i (rd_word_a),
        .dout_o    (bus.douta),
        .dvalid_o  (bus.dvalida)
    );

    mau_dp_ram_port #(
        .DATA_W     (DATA_W),
        .READ_MODE  (READ_MODE),
        .WRITE_MODE (WRITE_MODE)
    ) u_port_b (
        .clk       (clk),
        .resetn    (resetn),
        .busy_i    (busy),
        .ce_i      (bus.ceb),
        .wr_i      (bus.wreb),
        .be_i      (bus.beb),
        .din_i     (bus.dinb),
        .rd_word_i (rd_word_b),
        .dout_o    (bus.doutb),
        .dvalid_o  (bus.dvalidb)
    );

endmodule

// File: tb/tb_mau_dp_ram.sv
// tb/tb_mau_dp_ram.sv - self-checking bench for mau_dp_ram in three configurations
module tb_mau_dp_ram;
    import mau_dp_ram_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        init_req = 1'b0;
    logic        cea = 1'b0, wrea = 1'b0, ceb = 1'b0, wreb = 1'b0;
    logic [1:0]  bea = '0, beb = '0;
    logic [9:0]  ada = '0, adb = '0;
    logic [15:0] dina = '0, dinb = '0;

    always #5 clk = ~clk;

    // bus[0]: 1-cycle read-first, bus[1]: 2-cycle write-through, bus[2]: no clear on reset
    mau_dp_ram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_drive
        assign bus[g].init_req = init_req;
        assign bus[g].cea      = cea;
        assign bus[g].wrea     = wrea;
        assign bus[g].bea      = bea;
        assign bus[g].ada      = ada;
        assign bus[g].dina     = dina;
        assign bus[g].ceb      = ceb;
        assign bus[g].wreb     = wreb;
        assign bus[g].beb      = beb;
        assign bus[g].adb      = adb;
        assign bus[g].dinb     = dinb;
    end

    mau_dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_MODE(0), .WRITE_MODE(0),
                 .CLEAR_ON_RESET(1)) dut0 (.clk(clk), .resetn(resetn), .bus(bus[0]));
    mau_dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_MODE(1), .WRITE_MODE(1),
                 .CLEAR_ON_RESET(1)) dut1 (.clk(clk), .resetn(resetn), .bus(bus[1]));
    mau_dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_MODE(0), .WRITE_MODE(0),
                 .CLEAR_ON_RESET(0)) dut2 (.clk(clk), .resetn(resetn), .bus(bus[2]));

    // reference model
    logic [15:0] ref_mem [DEPTH];
    int          busy_left;
    logic [15:0] exp0a, exp0b, exp1a, exp1b;
    logic        p1a_v, p1b_v;
    logic [15:0] p1a_d, p1b_d;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] din,
                                          input logic [1:0] be);
        logic [15:0] w;
        w = old;
        if (be[0]) w[7:0]  = din[7:0];
        if (be[1]) w[15:8] = din[15:8];
        return w;
    endfunction

    task automatic idle();
        init_req = 1'b0;
        cea = 1'b0; wrea = 1'b0; bea = '0; ada = '0; dina = '0;
        ceb = 1'b0; wreb = 1'b0; beb = '0; adb = '0; dinb = '0;
    endtask

    task automatic acc_a(input logic wr, input logic [1:0] be, input logic [9:0] ad,
                         input logic [15:0] din);
        cea = 1'b1; wrea = wr; bea = be; ada = ad; dina = din;
    endtask

    task automatic acc_b(input logic wr, input logic [1:0] be, input logic [9:0] ad,
                         input logic [15:0] din);
        ceb = 1'b1; wreb = wr; beb = be; adb = ad; dinb = din;
    endtask

    task automatic rand_inputs(input bit with_init);
        cea  = 1'($urandom_range(0, 1));
        wrea = 1'($urandom_range(0, 1));
        bea  = 2'($urandom);
        ada  = 10'($urandom_range(0, 15));
        dina = 16'($urandom);
        ceb  = 1'($urandom_range(0, 1));
        wreb = 1'($urandom_range(0, 1));
        beb  = 2'($urandom);
        adb  = 10'($urandom_range(0, 15));
        dinb = 16'($urandom);
        init_req = with_init ? 1'($urandom_range(0, 1)) : 1'b0;
    endtask

    // One clock: predict from the model, advance the model, clock, compare.
    task automatic cycle();
        logic        busy_now, col;
        logic        r0a_v, r0b_v, r1a_v, r1b_v;
        logic [15:0] r0a_d, r0b_d, r1a_d, r1b_d;
        busy_now = (busy_left > 0);
        r0a_v = !busy_now && cea && !wrea;
        r0b_v = !busy_now && ceb && !wreb;
        r0a_d = ref_mem[ada];
        r0b_d = ref_mem[adb];
        r1a_v = !busy_now && cea;
        r1b_v = !busy_now && ceb;
        r1a_d = wrea ? merge(ref_mem[ada], dina, bea) : ref_mem[ada];
        r1b_d = wreb ? merge(ref_mem[adb], dinb, beb) : ref_mem[adb];
        col = !busy_now && cea && wrea && ceb && wreb && (ada == adb) && ((bea & beb) != 2'b00);
        if (busy_now) begin
            busy_left--;
        end else begin
            if (cea && wrea) ref_mem[ada] = merge(ref_mem[ada], dina, bea);
            if (ceb && wreb) ref_mem[adb] = merge(ref_mem[adb], dinb, beb);
            if (init_req) begin
                busy_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            end
        end
        @(posedge clk);
        #1;
        check_eq("busy0", 16'(bus[0].init_busy), 16'(busy_left > 0));
        check_eq("busy1", 16'(bus[1].init_busy), 16'(busy_left > 0));
        check_eq("dvalid0a", 16'(bus[0].dvalida), 16'(r0a_v));
        check_eq("dvalid0b", 16'(bus[0].dvalidb), 16'(r0b_v));
        if (r0a_v) exp0a = r0a_d;
        if (r0b_v) exp0b = r0b_d;
        check_eq("dout0a", bus[0].douta, exp0a);
        check_eq("dout0b", bus[0].doutb, exp0b);
        check_eq("dvalid1a", 16'(bus[1].dvalida), 16'(p1a_v));
        check_eq("dvalid1b", 16'(bus[1].dvalidb), 16'(p1b_v));
        if (p1a_v) exp1a = p1a_d;
        if (p1b_v) exp1b = p1b_d;
        check_eq("dout1a", bus[1].douta, exp1a);
        check_eq("dout1b", bus[1].doutb, exp1b);
        p1a_v = r1a_v; p1a_d = r1a_d;
        p1b_v = r1b_v; p1b_d = r1b_d;
        check_eq("collision0", 16'(bus[0].collision), 16'(col));
        check_eq("collision1", 16'(bus[1].collision), 16'(col));
    endtask

    task automatic step();
        cycle();
        idle();
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        idle();
        busy_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        exp0a = '0; exp0b = '0; exp1a = '0; exp1b = '0;
        p1a_v = 1'b0; p1b_v = 1'b0; p1a_d = '0; p1b_d = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
            check_eq("rst_dout0a", bus[0].douta, 16'h0000);
            check_eq("rst_dout1b", bus[1].doutb, 16'h0000);
            check_eq("rst_dvalid0", 16'({bus[0].dvalida, bus[0].dvalidb}), 16'h0000);
            check_eq("rst_dvalid1", 16'({bus[1].dvalida, bus[1].dvalidb}), 16'h0000);
            check_eq("rst_collision", 16'({bus[0].collision, bus[1].collision}), 16'h0000);
            check_eq("rst_busy0", 16'(bus[0].init_busy), 16'h0001);
            check_eq("rst_busy2", 16'(bus[2].init_busy), 16'h0000);
            check_eq("rst_dout2a", bus[2].douta, 16'h0000);
        end
        resetn = 1'b1;
    endtask

    // Runs until the clear finishes (bounded) and checks how long it lasted.
    task automatic wait_idle(input string tag, input bit rnd);
        int n;
        n = 0;
        while (n < 2000) begin
            if (rnd) rand_inputs(1'b1);
            else idle();
            cycle();
            n++;
            if (!bus[0].init_busy) break;
        end
        idle();
        check_eq(tag, 16'(n), 16'd1024);
    endtask

    initial begin
        #200000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        #1;
        do_reset(3);
        wait_idle("busy_len_por", 1'b1);

        // cleared array visible on both ports
        acc_a(1'b0, 2'b00, 10'd0, 16'h0);
        acc_b(1'b0, 2'b00, 10'd1023, 16'h0);
        step();
        check_eq("por_rd_a", bus[0].douta, 16'h0000);
        check_eq("por_rd_b", bus[0].doutb, 16'h0000);
        check_eq("por_dv_a", 16'(bus[0].dvalida), 16'h0001);
        step();
        check_eq("por_dv_pulse", 16'(bus[0].dvalida), 16'h0000);

        // byte-lane merge
        acc_a(1'b1, 2'b11, 10'h010, 16'h1234); step();
        acc_a(1'b1, 2'b01, 10'h010, 16'hABCD); step();
        check_eq("rf_no_dvalid", 16'(bus[0].dvalida), 16'h0000);
        acc_b(1'b1, 2'b11, 10'h011, 16'h3344); step();
        acc_a(1'b0, 2'b00, 10'h010, 16'h0); step();
        check_eq("be_merge", bus[0].douta, 16'h12CD);

        // two-cycle latency, back-to-back
        acc_b(1'b0, 2'b00, 10'h010, 16'h0); step();
        check_eq("rm1_not_yet", 16'(bus[1].dvalidb), 16'h0000);
        acc_b(1'b0, 2'b00, 10'h011, 16'h0); step();
        check_eq("rm1_first", bus[1].doutb, 16'h12CD);
        step();
        check_eq("rm1_second", bus[1].doutb, 16'h3344);
        check_eq("rm1_second_dv", 16'(bus[1].dvalidb), 16'h0001);

        // same-address double write
        acc_a(1'b1, 2'b11, 10'd5, 16'h1111);
        acc_b(1'b1, 2'b01, 10'd5, 16'h2222);
        step();
        check_eq("col_pulse", 16'(bus[0].collision), 16'h0001);
        acc_a(1'b0, 2'b00, 10'd5, 16'h0); step();
        check_eq("col_cleared", 16'(bus[0].collision), 16'h0000);
        check_eq("col_merge", bus[0].douta, 16'h1122);
        acc_a(1'b1, 2'b10, 10'd6, 16'h7777);
        acc_b(1'b1, 2'b01, 10'd6, 16'h8888);
        step();
        check_eq("col_disjoint", 16'(bus[0].collision), 16'h0000);

        // read vs write on the same address
        acc_a(1'b1, 2'b11, 10'd7, 16'h00AA); step();
        acc_a(1'b0, 2'b00, 10'd7, 16'h0);
        acc_b(1'b1, 2'b11, 10'd7, 16'h5555);
        step();
        check_eq("rw_old", bus[0].douta, 16'h00AA);
        acc_a(1'b0, 2'b00, 10'd7, 16'h0); step();
        check_eq("rw_wt_data", bus[1].doutb, 16'h5555);
        check_eq("rw_wt_dv", 16'(bus[1].dvalidb), 16'h0001);
        check_eq("rw_new", bus[0].douta, 16'h5555);

        // random traffic on a small address window
        repeat (1500) begin
            rand_inputs(1'b0);
            step();
        end

        // clear on request with writes attempted while busy
        acc_b(1'b1, 2'b11, 10'd900, 16'hBEEF); step();
        init_req = 1'b1; step();
        wait_idle("busy_len_init", 1'b1);
        for (int i = 0; i < 512; i++) begin
            acc_a(1'b0, 2'b00, 10'(i), 16'h0);
            acc_b(1'b0, 2'b00, 10'(i + 512), 16'h0);
            step();
        end

        // reset in the middle of a clear
        acc_a(1'b1, 2'b11, 10'd900, 16'hBEEF); step();
        init_req = 1'b1; step();
        repeat (300) begin
            rand_inputs(1'b1);
            step();
        end
        do_reset(2);
        wait_idle("busy_len_abort", 1'b0);
        acc_a(1'b0, 2'b00, 10'd900, 16'h0); step();
        check_eq("abort_cleared", bus[0].douta, 16'h0000);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
